perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CNT, default 8: number of counter channels, legal range 1..32.
REQ-002 Parameter CNT_WIDTH, default 32: bits per counter, legal range 8..64.
REQ-003 Parameter SATURATE, default 0: 0 = wrap on overflow, 1 = hold at all-ones.
REQ-004 Derived IDX_W = max(1, clog2(NUM_CNT)); it is not user-settable.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 ev_inc  input  NUM_CNT  per-channel increment strobe, +1 per asserted cycle.
REQ-008 cnt_en  input  NUM_CNT  per-channel count enable; strobe ignored when low.
REQ-009 halt  input  1  global freeze (ebreak); no channel counts while high.
REQ-010 clr_req  input  1  clear request for channel clr_idx.
REQ-011 clr_idx  input  IDX_W  channel selected by clr_req.
REQ-012 clr_all  input  1  clears every channel; overrides clr_req.
REQ-013 rd_req  input  1  read request for channel rd_idx.
REQ-014 rd_idx  input  IDX_W  channel selected by rd_req.
REQ-015 rd_valid  output  1  one-cycle pulse marking rd_data/rd_err/rd_ovf valid.
REQ-016 rd_data  output  CNT_WIDTH  read value.
REQ-017 rd_err  output  1  read index out of range.
REQ-018 rd_ovf  output  1  sticky overflow flag of the read channel.
REQ-019 ovf_any  output  1  OR of all sticky overflow flags.

Function
REQ-020 A channel increments by exactly 1 in a cycle iff ev_inc[i] & cnt_en[i] & ~halt.
REQ-021 Wrap mode: all-ones + 1 -> 0, and that channel's ovf flag sets in the same edge.
REQ-022 Saturate mode: all-ones + 1 -> remains all-ones, and the ovf flag sets.
REQ-023 ovf flags are sticky; only reset, clr_all, or clr_req for that channel clears them.
REQ-024 Clear and increment on the same channel in the same cycle -> value 0 and ovf 0; clear wins.
REQ-025 Read latency is 1 cycle: rd_req sampled at edge N produces rd_valid high after edge N, for exactly one cycle.
REQ-026 rd_data returns the value held before edge N; an increment at edge N is not visible.
REQ-027 Back-to-back rd_req on consecutive cycles is legal; one response is produced per request, with no stall.
REQ-028 rd_idx >= NUM_CNT -> rd_err 1, rd_data 0, rd_ovf 0, and rd_valid still pulses.
REQ-029 clr_req with clr_idx >= NUM_CNT is ignored with no side effects.
REQ-030 When rd_valid is low, rd_data, rd_err and rd_ovf are driven to 0.
REQ-031 A read and a clear of the same channel in one cycle return the pre-clear value.

Reset
REQ-032 Reset asserted clears all counters, ovf flags, rd_valid, rd_data, rd_err, rd_ovf and ovf_any to 0 asynchronously.
REQ-033 Reset mid-read drops the pending response; no rd_valid follows deassertion.
REQ-034 The first count is possible at the first rising edge after reset deasserts.

Configuration
REQ-035 Macro PERFCNT_SNAPSHOT_EN, when defined, adds input snap_req (1 bit) and a per-channel shadow register bank.
REQ-036 With the macro, snap_req copies all live counters to the shadows in one edge, using pre-increment values.
REQ-037 With the macro, reads return shadow values; shadows reset to 0 and are unaffected by clears.
REQ-038 Without the macro, snap_req and the shadows do not exist, and reads return live values.

Structure
REQ-039 Package perf_pkg holds the event index constants: EV_CYCLE=0, EV_INSTR=1, EV_MEM_RD=2, EV_MEM_WR=3, EV_RF_RD=4, EV_RF_WR=5, EV_BR_TAKEN=6, EV_STALL=7.
REQ-040 Sub-module perf_counter_cell implements one channel (counter, ovf flag, mode logic) and is instantiated NUM_CNT times via generate.

Verification
REQ-041 Scenario: NUM_CNT=8, ev_inc=8'hFF, cnt_en=8'h0F, 10 cycles -> ch0..3 read 10, ch4..7 read 0.
REQ-042 Scenario: CNT_WIDTH=8, SATURATE=0, 257 strobes on ch2 -> rd_data=1, rd_ovf=1, ovf_any=1; then clr_req idx2 -> reads 0 with ovf 0.
REQ-043 Scenario: CNT_WIDTH=8, SATURATE=1, 300 strobes on ch1 -> rd_data=255, rd_ovf=1.
REQ-044 Scenario: halt high for 5 of 12 strobe cycles on ch0 -> ch0=7; rd_idx=9 -> rd_err=1, rd_data=0, rd_valid pulses.
REQ-045 Scenario: clr_req and ev_inc on ch3 in the same cycle, value 20 -> next read 0; reset mid-count -> all reads 0.
REQ-046 Scenario (macro defined): ch0=5, snap_req, 3 more strobes -> read 5; second snap_req -> read 8.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance counter bank: event channel
// assignments and the index-width helper used to size the select ports.
package perf_pkg;

    typedef enum int unsigned {
        EV_CYCLE    = 0,
        EV_INSTR    = 1,
        EV_MEM_RD   = 2,
        EV_MEM_WR   = 3,
        EV_RF_RD    = 4,
        EV_RF_WR    = 5,
        EV_BR_TAKEN = 6,
        EV_STALL    = 7
    } perf_event_e;

    // Width of a channel index; a single-channel bank still has a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One performance counter channel: counter register, sticky overflow flag,
// and wrap/saturate behaviour at all-ones.
module perf_counter_cell #(
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // Next-state: clear beats increment; at all-ones either wrap or hold, flagging overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Counter and flag registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with per-channel enable, global halt,
// single/all clear and a one-cycle-latency read port.
// Optional macro PERFCNT_SNAPSHOT_EN adds snap_req and a shadow bank that
// reads are served from.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int  NUM_CNT   = 8,
    parameter int  CNT_WIDTH = 32,
    parameter int  SATURATE  = 0,
    localparam int IDX_W     = idx_width(NUM_CNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CNT-1:0]   ev_inc,
    input  logic [NUM_CNT-1:0]   cnt_en,
    input  logic                 halt,
    input  logic                 clr_req,
    input  logic [IDX_W-1:0]     clr_idx,
    input  logic                 clr_all,
`ifdef PERFCNT_SNAPSHOT_EN
    input  logic                 snap_req,
`endif
    input  logic                 rd_req,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 rd_err,
    output logic                 rd_ovf,
    output logic                 ovf_any
);

    logic [NUM_CNT-1:0]   inc;
    logic [NUM_CNT-1:0]   clr;
    logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf;
    logic [CNT_WIDTH-1:0] rd_src [NUM_CNT];

    logic                 rd_hit;
    logic [CNT_WIDTH-1:0] rd_sel_data;
    logic                 rd_sel_ovf;

    logic                 rd_valid_q, rd_valid_d;
    logic [CNT_WIDTH-1:0] rd_data_q,  rd_data_d;
    logic                 rd_err_q,   rd_err_d;
    logic                 rd_ovf_q,   rd_ovf_d;

    assign inc = ev_inc & cnt_en & {NUM_CNT{~halt}};

    // Clear decode; an index with no matching channel selects nothing.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            clr[i] = clr_all | (clr_req && (clr_idx == IDX_W'(i)));
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[g]),
            .clr   (clr[g]),
            .cnt   (cnt[g]),
            .ovf   (ovf[g])
        );
    end

`ifdef PERFCNT_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];

    // Shadow bank captures the registered (pre-increment) counts; clears do not touch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
        end else if (snap_req) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) shadow_q[i] <= cnt[i];
        end
    end

    assign rd_src = shadow_q;
`else
    assign rd_src = cnt;
`endif

    // Read select by comparison rather than array indexing so out-of-range indices simply miss.
    always_comb begin
        rd_hit      = 1'b0;
        rd_sel_data = '0;
        rd_sel_ovf  = 1'b0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_hit      = 1'b1;
                rd_sel_data = rd_src[i];
                rd_sel_ovf  = ovf[i];
            end
        end
    end

    // Response next-state; every field is zero unless a request is being answered.
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = (rd_req && rd_hit) ? rd_sel_data : '0;
        rd_err_d   = rd_req & ~rd_hit;
        rd_ovf_d   = rd_req & rd_hit & rd_sel_ovf;
    end

    // Response registers; reset drops any response in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign rd_ovf   = rd_ovf_q;
    assign ovf_any  = |ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: two instances sharing stimulus.
//   dut_a: NUM_CNT=9, CNT_WIDTH=8, wrap   (4-bit index, so index 9 is out of range)
//   dut_b: NUM_CNT=8, CNT_WIDTH=8, saturate (sees the low 8 event bits / 3 index bits)
module tb_perf_counter_bank;
    import perf_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] ev, en;
    logic       halt, clr_req, clr_all, rd_req;
    logic [3:0] clr_idx, rd_idx;
    logic       snap_req;

    logic       rd_valid_a, rd_err_a, rd_ovf_a, ovf_any_a;
    logic [7:0] rd_data_a;
    logic       rd_valid_b, rd_err_b, rd_ovf_b, ovf_any_b;
    logic [7:0] rd_data_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CNT(9), .CNT_WIDTH(8), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .ev_inc(ev), .cnt_en(en), .halt(halt),
        .clr_req(clr_req), .clr_idx(clr_idx), .clr_all(clr_all),
`ifdef PERFCNT_SNAPSHOT_EN
        .snap_req(snap_req),
`endif
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid_a),
        .rd_data(rd_data_a), .rd_err(rd_err_a), .rd_ovf(rd_ovf_a), .ovf_any(ovf_any_a)
    );

    perf_counter_bank #(.NUM_CNT(8), .CNT_WIDTH(8), .SATURATE(1)) dut_b (
        .clk(clk), .reset(reset), .ev_inc(ev[7:0]), .cnt_en(en[7:0]), .halt(halt),
        .clr_req(clr_req), .clr_idx(clr_idx[2:0]), .clr_all(clr_all),
`ifdef PERFCNT_SNAPSHOT_EN
        .snap_req(snap_req),
`endif
        .rd_req(rd_req), .rd_idx(rd_idx[2:0]), .rd_valid(rd_valid_b),
        .rd_data(rd_data_b), .rd_err(rd_err_b), .rd_ovf(rd_ovf_b), .ovf_any(ovf_any_b)
    );

    typedef struct {
        logic [8:0] ev;
        logic [8:0] en;
        logic       halt;
        int         n;
        logic [3:0] idx;
        logic [7:0] ea;
        logic       eerr;
        logic [7:0] eb;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [8:0] v, input int n);
        ev = v;
        repeat (n) step();
        ev = '0;
    endtask

    task automatic clear_all();
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
    endtask

    task automatic snap();
`ifdef PERFCNT_SNAPSHOT_EN
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
`endif
    endtask

    // Check the response visible one edge after a request.
    task automatic chk_resp(input string name, input logic [7:0] ea, input logic oa,
                            input logic erra, input logic [7:0] eb, input logic ob);
        chk({name, "/a_valid"}, {63'd0, rd_valid_a}, 64'd1);
        chk({name, "/a_data"},  {56'd0, rd_data_a},  {56'd0, ea});
        chk({name, "/a_err"},   {63'd0, rd_err_a},   {63'd0, erra});
        chk({name, "/a_ovf"},   {63'd0, rd_ovf_a},   {63'd0, oa});
        chk({name, "/b_valid"}, {63'd0, rd_valid_b}, 64'd1);
        chk({name, "/b_data"},  {56'd0, rd_data_b},  {56'd0, eb});
        chk({name, "/b_ovf"},   {63'd0, rd_ovf_b},   {63'd0, ob});
    endtask

    task automatic chk_idle(input string name);
        chk({name, "/a_valid"}, {63'd0, rd_valid_a}, 64'd0);
        chk({name, "/a_data"},  {56'd0, rd_data_a},  64'd0);
        chk({name, "/a_err"},   {63'd0, rd_err_a},   64'd0);
        chk({name, "/a_ovf"},   {63'd0, rd_ovf_a},   64'd0);
        chk({name, "/b_valid"}, {63'd0, rd_valid_b}, 64'd0);
        chk({name, "/b_data"},  {56'd0, rd_data_b},  64'd0);
    endtask

    task automatic rd(input string name, input bit do_snap, input logic [3:0] idx,
                      input logic [7:0] ea, input logic oa, input logic erra,
                      input logic [7:0] eb, input logic ob);
        if (do_snap) snap();
        rd_req = 1'b1;
        rd_idx = idx;
        step();
        rd_req = 1'b0;
        chk_resp(name, ea, oa, erra, eb, ob);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{ev: 9'h1FF, en: 9'h00F, halt: 1'b0, n: 10, idx: 4'd0, ea: 8'd10, eerr: 1'b0, eb: 8'd10};
        tbl[1] = '{ev: 9'h1FF, en: 9'h00F, halt: 1'b0, n: 10, idx: 4'd5, ea: 8'd0,  eerr: 1'b0, eb: 8'd0};
        tbl[2] = '{ev: 9'h1FF, en: 9'h1FF, halt: 1'b1, n: 6,  idx: 4'd3, ea: 8'd0,  eerr: 1'b0, eb: 8'd0};
        tbl[3] = '{ev: 9'h004, en: 9'h1FF, halt: 1'b0, n: 3,  idx: 4'd2, ea: 8'd3,  eerr: 1'b0, eb: 8'd3};
        tbl[4] = '{ev: 9'h004, en: 9'h1FB, halt: 1'b0, n: 3,  idx: 4'd2, ea: 8'd0,  eerr: 1'b0, eb: 8'd0};
        tbl[5] = '{ev: 9'h100, en: 9'h1FF, halt: 1'b0, n: 4,  idx: 4'd8, ea: 8'd4,  eerr: 1'b0, eb: 8'd0};
        tbl[6] = '{ev: 9'h0FF, en: 9'h0F0, halt: 1'b0, n: 5,  idx: 4'd7, ea: 8'd5,  eerr: 1'b0, eb: 8'd5};
        tbl[7] = '{ev: 9'h1FF, en: 9'h1FF, halt: 1'b0, n: 2,  idx: 4'd9, ea: 8'd0,  eerr: 1'b1, eb: 8'd2};

        reset = 1'b1;
        ev = '0; en = '0; halt = 1'b0;
        clr_req = 1'b0; clr_idx = '0; clr_all = 1'b0;
        rd_req = 1'b0; rd_idx = '0; snap_req = 1'b0;

        // Reset state
        repeat (2) step();
        chk_idle("reset");
        chk("reset/a_ovf_any", {63'd0, ovf_any_a}, 64'd0);
        chk("reset/b_ovf_any", {63'd0, ovf_any_b}, 64'd0);

        // First count at the first edge after reset release
        reset = 1'b0;
        en = '1;
        strobe(9'h001, 1);
        rd("first_cnt", 1'b1, 4'(EV_CYCLE), 8'd1, 1'b0, 1'b0, 8'd1, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            clear_all();
            en   = tbl[i].en;
            halt = tbl[i].halt;
            strobe(tbl[i].ev, tbl[i].n);
            halt = 1'b0;
            en   = '1;
            rd($sformatf("vec%0d", i), 1'b1, tbl[i].idx, tbl[i].ea, 1'b0, tbl[i].eerr, tbl[i].eb, 1'b0);
        end
        step();
        chk_idle("idle_after_err");

        // Halt for 5 of 12 strobe cycles on ch0
        clear_all();
        ev = 9'h001;
        for (int i = 0; i < 12; i++) begin
            halt = (i >= 3 && i < 8);
            step();
        end
        ev = '0; halt = 1'b0;
        rd("halt", 1'b1, 4'(EV_CYCLE), 8'd7, 1'b0, 1'b0, 8'd7, 1'b0);

        // 257 strobes on ch2: A wraps to 1, B sticks at 255
        clear_all();
        strobe(9'h004, 257);
        rd("wrap257", 1'b1, 4'(EV_MEM_RD), 8'd1, 1'b1, 1'b0, 8'd255, 1'b1);
        chk("wrap257/a_ovf_any", {63'd0, ovf_any_a}, 64'd1);
        chk("wrap257/b_ovf_any", {63'd0, ovf_any_b}, 64'd1);
        clr_req = 1'b1; clr_idx = 4'd2;
        step();
        clr_req = 1'b0;
        rd("clr2", 1'b1, 4'd2, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("clr2/a_ovf_any", {63'd0, ovf_any_a}, 64'd0);
        chk("clr2/b_ovf_any", {63'd0, ovf_any_b}, 64'd0);

        // All-ones boundary on ch3
        clear_all();
        strobe(9'h008, 255);
        rd("b255", 1'b1, 4'd3, 8'd255, 1'b0, 1'b0, 8'd255, 1'b0);
        strobe(9'h008, 1);
        rd("b256", 1'b1, 4'd3, 8'd0, 1'b1, 1'b0, 8'd255, 1'b1);
        strobe(9'h008, 1);
        rd("b257", 1'b1, 4'd3, 8'd1, 1'b1, 1'b0, 8'd255, 1'b1);

        // 300 strobes on ch1; overflow stays sticky across a clear of another channel
        clear_all();
        strobe(9'h002, 300);
        rd("sat300", 1'b1, 4'(EV_INSTR), 8'd44, 1'b1, 1'b0, 8'd255, 1'b1);
        clr_req = 1'b1; clr_idx = 4'd0;
        step();
        clr_req = 1'b0;
        rd("sticky", 1'b1, 4'd1, 8'd44, 1'b1, 1'b0, 8'd255, 1'b1);
        chk("sticky/a_ovf_any", {63'd0, ovf_any_a}, 64'd1);

        // Clear and increment together on ch3: clear wins
        clear_all();
        strobe(9'h008, 20);
        rd("pre_clr20", 1'b1, 4'd3, 8'd20, 1'b0, 1'b0, 8'd20, 1'b0);
        ev = 9'h008; clr_req = 1'b1; clr_idx = 4'd3;
        step();
        ev = '0; clr_req = 1'b0;
        rd("clr_vs_inc", 1'b1, 4'd3, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Out-of-range clear (index 9) is ignored by A; B sees index 1
        clear_all();
        strobe(9'h003, 5);
        clr_req = 1'b1; clr_idx = 4'd9;
        step();
        clr_req = 1'b0;
        rd("oor_clr_ch1", 1'b1, 4'd1, 8'd5, 1'b0, 1'b0, 8'd0, 1'b0);
        rd("oor_clr_ch0", 1'b1, 4'd0, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0);

        // Back-to-back reads: read during increment, read during clear, then live vs shadow
        snap();
        rd_req = 1'b1; rd_idx = 4'd0; ev = 9'h001;
        step();
        ev = '0;
        chk_resp("b2b_inc", 8'd5, 1'b0, 1'b0, 8'd5, 1'b0);
        rd_idx = 4'd1; clr_req = 1'b1; clr_idx = 4'd1;
        step();
        clr_req = 1'b0;
        chk_resp("b2b_clr", 8'd5, 1'b0, 1'b0, 8'd0, 1'b0);
        rd_idx = 4'd0;
        step();
        rd_req = 1'b0;
`ifdef PERFCNT_SNAPSHOT_EN
        chk_resp("b2b_post", 8'd5, 1'b0, 1'b0, 8'd5, 1'b0);
`else
        chk_resp("b2b_post", 8'd6, 1'b0, 1'b0, 8'd6, 1'b0);
`endif
        step();
        chk_idle("b2b_idle");
        rd("b2b_ch1", 1'b1, 4'd1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Reset while a response is visible and while a request is pending
        strobe(9'h1FF, 3);
        rd_req = 1'b1; rd_idx = 4'd0;
        step();
        chk("rst_mid/a_valid_pre", {63'd0, rd_valid_a}, 64'd1);
        reset = 1'b1;
        #1;
        chk_idle("rst_mid_async");
        chk("rst_mid/a_ovf_any", {63'd0, ovf_any_a}, 64'd0);
        rd_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk_idle("rst_mid_after");
        rd("rst_ch0", 1'b1, 4'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        rd("rst_ch5", 1'b1, 4'd5, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);

`ifdef PERFCNT_SNAPSHOT_EN
        // Snapshot: reads come from shadows, which ignore clears
        clear_all();
        strobe(9'h001, 5);
        snap();
        strobe(9'h001, 3);
        rd("snap5", 1'b0, 4'd0, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0);
        snap();
        rd("snap8", 1'b0, 4'd0, 8'd8, 1'b0, 1'b0, 8'd8, 1'b0);
        clear_all();
        rd("snap_keep", 1'b0, 4'd0, 8'd8, 1'b0, 1'b0, 8'd8, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
